// File: rtl/addr_sweep_pkg.sv
// Shared types for the address-sweep controller: FSM states, address width, grant decode helper.
// Consumed by addr_sweep_ctrl and sweep_arb2 (ADDR_SWEEP_RR_EN selects round-robin arbitration).
package addr_sweep_pkg;

  localparam int SWEEP_AW = 5;

  typedef logic [SWEEP_AW-1:0] sweep_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } sweep_state_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sweep_arb2.sv
// Combinational 2-way arbiter; with ADDR_SWEEP_RR_EN a registered last-served pointer breaks ties,
// otherwise requester 0 always wins. Zero latency, pointer moves only when upd_i is high.
module sweep_arb2 (
  input  logic [1:0] req_i,
  output logic       idx_o
`ifdef ADDR_SWEEP_RR_EN
  ,
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       upd_i,
  input  logic       served_i
`endif
);

`ifdef ADDR_SWEEP_RR_EN
  logic last_q;

  // Reset to "requester 1 served last" so requester 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (upd_i) begin
      last_q <= served_i;
    end
  end

  always_comb begin
    idx_o = 1'b0;
    if (req_i == 2'b11) begin
      idx_o = ~last_q;
    end else if (req_i[1]) begin
      idx_o = 1'b1;
    end
  end
`else
  assign idx_o = req_i[1] & ~req_i[0];
`endif

endmodule

// File: rtl/addr_sweep_ctrl.sv
// Two-requester address sweep over a 2^AW space: first valid 2 cycles after req, 1 beat/cycle,
// ADDRESS holds while addr_ready is low. Arbitration mode set by ADDR_SWEEP_RR_EN.
module addr_sweep_ctrl
  import addr_sweep_pkg::*;
#(
  parameter int AW   = SWEEP_AW,
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [AW-1:0]   base0,
  input  logic [AW-1:0]   base1,
  input  logic [AW-1:0]   len0,
  input  logic [AW-1:0]   len1,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic [AW-1:0]   ADDRESS,
  output logic            addr_valid,
  input  logic            addr_ready,
  output logic            addr_last,
  output logic [NREQ-1:0] done
);

  sweep_state_e  state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] base_sel, len_sel, cnt_inc;
  logic          last_q, last_d;
  logic          win_q, win_d;
  logic          arb_idx;

`ifdef ADDR_SWEEP_RR_EN
  logic arb_upd;
  assign arb_upd = (state_q == DONE);
`endif

  sweep_arb2 u_arb (
    .req_i    (req),
    .idx_o    (arb_idx)
`ifdef ADDR_SWEEP_RR_EN
    ,
    .clk_i    (clk),
    .rst_i    (rst),
    .upd_i    (arb_upd),
    .served_i (win_q)
`endif
  );

  assign base_sel = win_q ? base1 : base0;
  assign len_sel  = win_q ? len1 : len0;
  assign cnt_inc  = cnt_q + AW'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    last_d  = last_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d   = arb_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        addr_d  = base_sel;
        cnt_d   = '0;
        len_d   = len_sel;
        last_d  = (len_sel == '0);
        state_d = RUN;
      end
      RUN: begin
        if (addr_ready) begin
          if (last_q) begin
            last_d  = 1'b0;
            state_d = DONE;
          end else begin
            // Address wraps naturally at the AW-bit boundary.
            addr_d = addr_q + AW'(1);
            cnt_d  = cnt_inc;
            last_d = (cnt_inc == len_q);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      last_q  <= last_d;
      win_q   <= win_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign addr_valid = (state_q == RUN);
  assign ADDRESS    = addr_q;
  assign addr_last  = last_q;
  assign gnt        = (state_q == LOAD || state_q == RUN) ? onehot2(win_q) : '0;
  assign done       = (state_q == DONE) ? onehot2(win_q) : '0;

endmodule

// File: tb/tb_addr_sweep_ctrl.sv
// Randomized and directed bench for addr_sweep_ctrl against a sweep-level reference model.
// Expected addresses come from (base + beat) mod 32; grants from the requester/tie rules.
module tb_addr_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [4:0] base0, base1, len0, len1;
  logic [1:0] gnt;
  logic       busy;
  logic [4:0] ADDRESS;
  logic       addr_valid;
  logic       addr_ready;
  logic       addr_last;
  logic [1:0] done;

  int total = 0;
  int bad   = 0;

`ifdef ADDR_SWEEP_RR_EN
  int rr_last = 1;
`endif

  addr_sweep_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .base0      (base0),
    .base1      (base1),
    .len0       (len0),
    .len1       (len1),
    .gnt        (gnt),
    .busy       (busy),
    .ADDRESS    (ADDRESS),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_last  (addr_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int w);
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic int model_winner(input logic [1:0] rq);
    if (rq == 2'b11) begin
`ifdef ADDR_SWEEP_RR_EN
      return (rr_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return (rq == 2'b10) ? 1 : 0;
  endfunction

  // mode 0: ready always high; 1: random ready; 2: ready from pat, one bit per valid cycle
  task automatic run_sweep(input logic [1:0] rq, input int mode, input logic [31:0] pat,
                           input bit scramble, input bit hold, input int lat, input string tag);
    int w, b, l, k, cyc, vidx, first, last_acc;
    bit got;
    w = model_winner(rq);
    b = (w == 1) ? int'(base1) : int'(base0);
    l = (w == 1) ? int'(len1) : int'(len0);
    req = rq;
    addr_ready = 1'b1;
    k = 0; cyc = 0; vidx = 0; first = -1; last_acc = -1; got = 1'b0;
    while (!got && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (addr_valid) begin
        case (mode)
          0:       addr_ready = 1'b1;
          1:       addr_ready = 1'($urandom_range(0, 1));
          default: addr_ready = (vidx < 32) ? pat[vidx] : 1'b1;
        endcase
        vidx++;
        if (first < 0) begin
          first = cyc;
          chk({tag, " first_valid_latency"}, first, lat);
          chk({tag, " gnt"}, gnt, oh(w));
          chk({tag, " busy"}, busy, 1);
        end
        chk({tag, " addr"}, ADDRESS, (b + k) % 32);
        chk({tag, " last"}, addr_last, (k == l) ? 1 : 0);
        if (scramble) begin
          base0 = 5'($urandom);
          len0  = 5'($urandom);
        end
        if (addr_ready) begin
          last_acc = cyc;
          k++;
        end
      end else if (done !== 2'b00) begin
        got = 1'b1;
        chk({tag, " done"}, done, oh(w));
        chk({tag, " beats"}, k, l + 1);
        chk({tag, " done_delay"}, cyc, last_acc + 1);
`ifdef ADDR_SWEEP_RR_EN
        rr_last = w;
`endif
        if (!hold) req = 2'b00;
      end
    end
    chk({tag, " done_seen"}, got, 1);
    if (!hold) begin
      @(posedge clk);
      #1;
      chk({tag, " done_pulse_width"}, done, 0);
      chk({tag, " idle_busy"}, busy, 0);
    end
  endtask

  initial begin
    int acc, cyc;
    rst = 1'b1; req = 2'b00; addr_ready = 1'b0;
    base0 = '0; base1 = '0; len0 = '0; len1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset addr", ADDRESS, 0);
    chk("reset valid", addr_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset gnt", gnt, 0);
    chk("reset done", done, 0);
    chk("reset last", addr_last, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle no req busy", busy, 0);

    base0 = 5'd3; len0 = 5'd4;
    run_sweep(2'b01, 0, 32'h0, 1'b0, 1'b0, 2, "basic");

    base1 = 5'd30; len1 = 5'd3;
    run_sweep(2'b10, 0, 32'h0, 1'b0, 1'b0, 2, "wrap");

    base0 = 5'd0; len0 = 5'd2;
    run_sweep(2'b01, 2, 32'b11001, 1'b0, 1'b0, 2, "stall");

    base0 = 5'd0; len0 = 5'd31;
    run_sweep(2'b01, 0, 32'h0, 1'b1, 1'b0, 2, "full");

    base0 = 5'd9; base1 = 5'd17; len0 = 5'd0; len1 = 5'd0;
    run_sweep(2'b11, 0, 32'h0, 1'b0, 1'b1, 2, "cont0");
    run_sweep(2'b11, 0, 32'h0, 1'b0, 1'b1, 3, "cont1");
    run_sweep(2'b11, 0, 32'h0, 1'b0, 1'b0, 3, "cont2");

    for (int i = 0; i < 8; i++) begin
      base0 = 5'($urandom); base1 = 5'($urandom);
      len0  = 5'($urandom); len1  = 5'($urandom);
      run_sweep(2'($urandom_range(1, 3)), 1, 32'h0, 1'b0, 1'b0, 2, "rand");
    end

    base0 = 5'd5; len0 = 5'd1;
    run_sweep(2'b01, 0, 32'h0, 1'b0, 1'b0, 2, "pre_rst");

    base0 = 5'd10; len0 = 5'd4;
    req = 2'b01; addr_ready = 1'b1;
    acc = 0; cyc = 0;
    while (acc < 2 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (addr_valid) acc++;
    end
    @(posedge clk);
    #1;
    chk("rst_mid beat2 addr", ADDRESS, 12);
    chk("rst_mid beat2 valid", addr_valid, 1);
    rst = 1'b1; req = 2'b00;
    @(posedge clk);
    #1;
    chk("rst_mid addr", ADDRESS, 0);
    chk("rst_mid valid", addr_valid, 0);
    chk("rst_mid busy", busy, 0);
    chk("rst_mid gnt", gnt, 0);
    chk("rst_mid done", done, 0);
    chk("rst_mid last", addr_last, 0);
    rst = 1'b0;
`ifdef ADDR_SWEEP_RR_EN
    rr_last = 1;
`endif
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_mid no done", done, 0);
    end

    base0 = 5'd7; base1 = 5'd20; len0 = 5'd0; len1 = 5'd0;
    run_sweep(2'b11, 0, 32'h0, 1'b0, 1'b0, 2, "post_rst_cont");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addr_sweep_ctrl.md
# addr_sweep_ctrl

Synchronous address-sweep controller for the 5-bit, 32-entry address space that feeds table and ROM lookups in the FPU and processor datapath. It shares that address space between two requesters. Each requester asks for a contiguous sweep given as a base address and a length, and the block issues one address per accepted beat with a valid/ready handshake, wrapping modulo 32. It replaces free-running address counting wherever a sweep must start at an arbitrary base, stall, or be shared.

## Interface
Parameters:
- `AW`, 5, address width; the address space has 2^AW entries.
- `NREQ`, 2, number of requesters; fixed at 2 in this revision.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  2  per-requester sweep request; level-sensitive.
- `base0`, `base1`  in  AW  start address of the requester's sweep.
- `len0`, `len1`  in  AW  beat count minus one (0 gives 1 beat, 31 gives 32 beats).
- `gnt`  out  2  one-hot; marks the requester currently owning the sweep.
- `busy`  out  1  high in every state except IDLE.
- `ADDRESS`  out  AW  current address.
- `addr_valid`  out  1  `ADDRESS` is valid this cycle.
- `addr_ready`  in  1  consumer accepts the beat when `addr_valid` and `addr_ready` are both high.
- `addr_last`  out  1  the current beat is the final beat of the sweep.
- `done`  out  2  one-cycle pulse on the served requester's bit after its last beat is accepted.

## Operation
- The FSM has four states: IDLE, LOAD, RUN, DONE.
- IDLE: if `req` is nonzero, arbitrate and go to LOAD. Otherwise stay in IDLE.
- LOAD (1 cycle):
  - register the winner's base and length;
  - `ADDRESS` ← base; beat counter ← 0;
  - drive `gnt` one-hot to the winner;
  - go to RUN.
- RUN:
  - `addr_valid` is 1.
  - On acceptance of a beat that is not the last: `ADDRESS` ← `ADDRESS`+1 modulo 32 (31 wraps to 0), and the beat counter increments.
  - `addr_last` = (beat counter == registered length).
  - On acceptance with `addr_last` high: go to DONE.
  - Without acceptance, `ADDRESS` and the beat counter hold.
- DONE (1 cycle):
  - `done[winner]` = 1 and `addr_valid` = 0;
  - clear `gnt`;
  - update the round-robin pointer;
  - go to IDLE.
- Base and length are captured in LOAD. Later changes to `base*`/`len*`, or deassertion of `req`, have no effect until the sweep finishes; the sweep always runs to completion.
- A requester that still holds `req` after its `done` is arbitrated again from IDLE.
- Reset sets the state to IDLE, `ADDRESS` to 0, and `gnt`, `done`, `busy`, `addr_valid`, `addr_last` to 0. The round-robin pointer resets to favour requester 0.
- Reset asserted mid-sweep abandons the sweep: no `done` pulse, and IDLE on the next edge.

## Timing
- Latency from `req` rising in IDLE to the first valid address is 2 cycles (IDLE→LOAD, LOAD→RUN).
- With `addr_ready` held high, one beat is accepted per cycle. A sweep of N beats takes N cycles in RUN plus 1 cycle in DONE.
- Minimum time from one `done` to the next sweep's first valid beat is 3 cycles (DONE, IDLE, LOAD).
- `ADDRESS` and `addr_last` are registered, not combinational from `addr_ready`. `addr_valid` is decoded from state only.
- `addr_valid` never drops in RUN until the last beat is accepted.

## Configuration
- Controlled by the macro `ADDR_SWEEP_RR_EN`.
- Defined: round-robin arbitration. When both requesters request in IDLE, the one not served most recently wins. The pointer updates only in DONE.
- Undefined: fixed priority, requester 0 always wins. The pointer register is not built.

## Structure
- Shared package `addr_sweep_pkg` holds:
  - the state enum `sweep_state_e` (IDLE, LOAD, RUN, DONE);
  - `localparam` `SWEEP_AW` = 5;
  - the typedef `sweep_addr_t` (logic [SWEEP_AW-1:0]).
- One sub-module, `sweep_arb2`: a combinational 2-way arbiter with a registered last-served pointer and enable. It contains the `ADDR_SWEEP_RR_EN` selection.
- The top module holds the FSM, the address register and the beat counter.

## Test plan
- Reset, then `req`=01, `base0`=3, `len0`=4, `addr_ready`=1:
  - `ADDRESS` sequence 3,4,5,6,7;
  - `addr_last` high only on 7;
  - `done`=01 one cycle later;
  - first valid 2 cycles after `req`.
- Wrap: `base1`=30, `len1`=3, `req`=10 → `ADDRESS` sequence 30,31,0,1; `done`=10.
- Stall: `base0`=0, `len0`=2, `addr_ready` toggling 1,0,0,1,1 → `ADDRESS` sequence 0,1,1,1,2; no beat skipped or repeated in acceptance.
- Contention: `req`=11 held, both `len`=0.
  - With `ADDR_SWEEP_RR_EN`: grants alternate 01,10,01.
  - Without it: always 01.
- Full range: `len0`=31, `base0`=0 → 32 beats, 0 through 31, `done` after beat 31. Changing `base0`/`len0` mid-sweep has no effect.
- Reset at beat 2 of a 5-beat sweep → next edge: IDLE, `ADDRESS`=0, `addr_valid`=0, no `done` pulse.
